// File: rtl/regfile.sv
// 32x32 RISC-V integer register file: two combinational read ports,
// one write port with write-through bypass, synchronous active-high reset.
//   clk_i, rst_i            : clock, sync reset (clears all registers)
//   we_i, waddr_i, wdata_i  : write port (writes to x0 are dropped)
//   raddr1_i/2_i, rdata1_o/2_o : read ports
module regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];
  logic        wen_d;

  assign wen_d = we_i && (waddr_i != 5'd0);

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen_d) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle write is forwarded so a reader never sees stale data.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (rst_i || raddr1_i == 5'd0) begin
      rdata1_o = '0;
    end else if (we_i && waddr_i == raddr1_i) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (rst_i || raddr2_i == 5'd0) begin
      rdata2_o = '0;
    end else if (we_i && waddr_i == raddr2_i) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: reference model + per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [32];

  regfile dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr1_i(raddr1),
    .raddr2_i(raddr2),
    .rdata1_o(rdata1),
    .rdata2_o(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural state update.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
  end

  // Per-cycle compare, mid-cycle.
  always @(negedge clk) begin
    chk("cyc_rd1", rdata1, exp_rd(raddr1));
    chk("cyc_rd2", rdata2, exp_rd(raddr2));
  end

  task automatic cyc(input logic r, input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] a1,
                     input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0;

    // Reset for two cycles, then read every index.
    cyc(1, 1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd4);
    chk("rst_rd1", rdata1, 32'h0);
    chk("rst_rd2", rdata2, 32'h0);
    cyc(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      chk("post_rst_rd1", rdata1, 32'h0);
      chk("post_rst_rd2", rdata2, 32'h0);
    end

    // Write x5, read it on both ports next cycle.
    cyc(0, 1, 5'd5, 32'h0000_1234, 5'd1, 5'd2);
    cyc(0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("x5_rd1", rdata1, 32'h0000_1234);
    chk("x5_rd2", rdata2, 32'h0000_1234);

    // Writes to x0 are discarded, even for bypass.
    cyc(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5);
    chk("x0_same", rdata1, 32'h0);
    cyc(0, 0, 5'd0, 32'h0, 5'd0, 5'd5);
    chk("x0_next", rdata1, 32'h0);

    // Bypass on port 2.
    cyc(0, 1, 5'd7, 32'hAAAA_AAAA, 5'd0, 5'd0);
    cyc(0, 1, 5'd7, 32'h5555_5555, 5'd7, 5'd7);
    chk("byp_rd2", rdata2, 32'h5555_5555);
    chk("byp_rd1", rdata1, 32'h5555_5555);
    cyc(0, 0, 5'd7, 32'h0, 5'd0, 5'd7);
    chk("x7_after", rdata2, 32'h5555_5555);

    // Consecutive writes to x3; x4 must be untouched.
    cyc(0, 1, 5'd4, 32'h0000_CAFE, 5'd0, 5'd0);
    cyc(0, 1, 5'd3, 32'h0000_0001, 5'd0, 5'd0);
    cyc(0, 1, 5'd3, 32'h0000_0002, 5'd0, 5'd0);
    cyc(0, 0, 5'd3, 32'h0000_0009, 5'd3, 5'd4);
    chk("x3_last", rdata1, 32'h0000_0002);
    chk("x4_keep", rdata2, 32'h0000_CAFE);
    cyc(0, 0, 5'd0, 32'h0, 5'd5, 5'd7);
    chk("x5_keep", rdata1, 32'h0000_1234);
    chk("x7_keep", rdata2, 32'h5555_5555);

    // Reset wins over a simultaneous write.
    cyc(0, 1, 5'd9, 32'h0000_0042, 5'd0, 5'd0);
    cyc(0, 0, 5'd0, 32'h0, 5'd9, 5'd9);
    chk("x9_pre", rdata1, 32'h0000_0042);
    cyc(1, 1, 5'd9, 32'h0000_0099, 5'd9, 5'd9);
    chk("rst_byp_rd1", rdata1, 32'h0);
    chk("rst_byp_rd2", rdata2, 32'h0);
    cyc(0, 1, 5'd10, 32'h0000_0077, 5'd9, 5'd4);
    chk("x9_cleared", rdata1, 32'h0);
    chk("x4_cleared", rdata2, 32'h0);
    cyc(0, 0, 5'd0, 32'h0, 5'd10, 5'd3);
    chk("resume_x10", rdata1, 32'h0000_0077);
    chk("x3_cleared", rdata2, 32'h0);

    // Mixed traffic checked by the per-cycle compare.
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
          5'($urandom_range(0, 31)), $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
